// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-deep valid/ready pipeline register chain with bubble collapsing,
// synchronous flush and occupancy count. Define PIPE_PARITY_EN to add per-stage parity and par_err.

module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_PARITY_EN
    ,
    output logic                         par_err
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  r;
    logic [DATA_W-1:0] d [DEPTH];
    logic [CTRL_W-1:0] c [DEPTH];
`ifdef PIPE_PARITY_EN
    logic [DEPTH-1:0]  p;
`endif

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic              up_v;
        logic [DATA_W-1:0] up_d;
        logic [CTRL_W-1:0] up_c;
        logic              v_q;
        logic [DATA_W-1:0] d_q;
        logic [CTRL_W-1:0] c_q;

        // Closed form of r[k] = !v[k] | r[k+1]: stage k can advance if any stage from k
        // to the output is empty or the output is being drained.
        assign r[k] = out_ready | ~(&v[DEPTH-1:k]);

        if (k == 0) begin : g_src
            assign up_v = in_valid;
            assign up_d = in_data;
            assign up_c = in_ctrl;
        end else begin : g_src
            assign up_v = v[k-1];
            assign up_d = d[k-1];
            assign up_c = c[k-1];
        end

        // NOTE: the payload register is reset as well so out_data reads 0 straight out of reset;
        // it is not reset-free storage here.
        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                v_q <= 1'b0;
                d_q <= '0;
                c_q <= '0;
            end else if (flush) begin
                v_q <= 1'b0;
                c_q <= '0;
            end else if (r[k]) begin
                v_q <= up_v;
                c_q <= up_v ? up_c : '0;
                if (up_v) begin
                    d_q <= up_d;
                end
            end
        end

        assign v[k] = v_q;
        assign d[k] = d_q;
        assign c[k] = c_q;

`ifdef PIPE_PARITY_EN
        logic up_p;
        logic p_q;

        if (k == 0) begin : g_par_src
            assign up_p = ^{in_data, in_ctrl};
        end else begin : g_par_src
            assign up_p = p[k-1];
        end

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                p_q <= 1'b0;
            end else if (flush) begin
                p_q <= 1'b0;
            end else if (r[k]) begin
                p_q <= up_v ? up_p : 1'b0;
            end
        end

        assign p[k] = p_q;
`endif
    end

    assign in_ready  = r[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign out_ctrl  = c[DEPTH-1];
    assign occupancy = OCC_W'($countones(v));

`ifdef PIPE_PARITY_EN
    assign par_err = out_valid & (^{out_data, out_ctrl, p[DEPTH-1]});
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain (DEPTH=3): directed streaming, backpressure,
// bubble-collapse, flush and asynchronous-reset vectors.

module tb_pipe_stage_chain;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;
    localparam int DEPTH  = 3;
    localparam int OCC_W  = $clog2(DEPTH+1);

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } entry_t;

    logic              Clk;
    logic              Reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [OCC_W-1:0]  occupancy;
`ifdef PIPE_PARITY_EN
    logic              par_err;
`endif

    entry_t exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    bit     corrupting = 1'b0;

    pipe_stage_chain #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
`ifdef PIPE_PARITY_EN
        ,
        .par_err   (par_err)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Entries the vector expects the chain to accept are queued at issue time.
    task automatic drive(input logic v, input logic [DATA_W-1:0] dd, input logic [CTRL_W-1:0] cc,
                         input bit accept);
        in_valid = v;
        in_data  = dd;
        in_ctrl  = cc;
        if (accept) exp_q.push_back(entry_t'{dd, cc});
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge Clk) begin : mon
        entry_t e;
        if (Reset) begin
            if (!out_valid) check("ctrl_zero_when_idle", 64'(out_ctrl), 64'h0);
            check("occ_bound", 64'(occupancy <= OCC_W'(DEPTH)), 64'h1);
`ifdef PIPE_PARITY_EN
            if (!corrupting) check("par_err_clean", 64'(par_err), 64'h0);
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0h, expected no entry (t=%0t)", out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.d));
                    check("out_ctrl", 64'(out_ctrl), 64'(e.c));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        flush = 1'b0; out_ready = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data",  64'(out_data),  64'h0);
        check("rst_out_ctrl",  64'(out_ctrl),  64'h0);
        check("rst_occupancy", 64'(occupancy), 64'h0);
        check("rst_in_ready",  64'(in_ready),  64'h1);
        tick();
        Reset = 1'b1;
        tick();

        // Streaming at full rate.
        out_ready = 1'b1;
        drive(1, 32'h11, 16'h1100, 1);
        tick(); check("stream_occ1", 64'(occupancy), 64'd1); check("stream_v0", 64'(out_valid), 64'h0);
        drive(1, 32'h22, 16'h2200, 1);
        tick(); check("stream_occ2", 64'(occupancy), 64'd2); check("stream_v1", 64'(out_valid), 64'h0);
        drive(1, 32'h33, 16'h3300, 1);
        tick(); check("stream_occ_peak", 64'(occupancy), 64'd3); check("stream_lat", 64'(out_data), 64'h11);
        drive(0, 32'h0, 16'h0, 0);
        tick(); check("stream_d2", 64'(out_data), 64'h22);
        tick(); check("stream_d3", 64'(out_data), 64'h33); check("stream_v_last", 64'(out_valid), 64'h1);
        tick(); check("stream_empty", 64'(out_valid), 64'h0); check("stream_occ0", 64'(occupancy), 64'd0);

        // Backpressure with a full chain.
        out_ready = 1'b0;
        drive(1, 32'hA1, 16'h00A1, 1); tick();
        drive(1, 32'hA2, 16'h00A2, 1); tick();
        drive(1, 32'hA3, 16'h00A3, 1); tick();
        drive(1, 32'hA4, 16'h00A4, 0);
        #1;
        check("bp_in_ready", 64'(in_ready), 64'h0);
        check("bp_occ", 64'(occupancy), 64'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_data", 64'(out_data), 64'hA1);
            check("bp_hold_occ", 64'(occupancy), 64'd3);
            check("bp_hold_ready", 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        drive(1, 32'hA4, 16'h00A4, 1);
        #1;
        check("bp_ready_same_cycle", 64'(in_ready), 64'h1);
        tick();
        drive(0, 32'h0, 16'h0, 0);
        tick(); tick(); tick();
        check("bp_drained", 64'(occupancy), 64'd0);

        // Bubble collapse while the output stalls.
        out_ready = 1'b0;
        drive(1, 32'hB1, 16'h00B1, 1); tick();
        drive(0, 32'h0, 16'h0, 0);     tick();
        drive(1, 32'hB2, 16'h00B2, 1); tick();
        drive(0, 32'h0, 16'h0, 0);     tick();
        check("bubble_occ", 64'(occupancy), 64'd2);
        check("bubble_in_ready", 64'(in_ready), 64'h1);
        check("bubble_head", 64'(out_data), 64'hB1);
        out_ready = 1'b1;
        tick();
        check("bubble_adjacent_v", 64'(out_valid), 64'h1);
        check("bubble_adjacent_d", 64'(out_data), 64'hB2);
        check("bubble_occ1", 64'(occupancy), 64'd1);
        tick();
        check("bubble_empty", 64'(occupancy), 64'd0);

        // Flush a full, stalled chain.
        out_ready = 1'b0;
        drive(1, 32'hC1, 16'hFFFF, 1); tick();
        drive(1, 32'hC2, 16'hFFFF, 1); tick();
        drive(1, 32'hC3, 16'hFFFF, 1); tick();
        check("flush_full", 64'(occupancy), 64'd3);
        flush = 1'b1;
        drive(1, 32'hC4, 16'hFFFF, 0);
        #1;
        check("flush_in_ready", 64'(in_ready), 64'h0);
        check("flush_ctrl_pre", 64'(out_ctrl), 64'hFFFF);
        tick();
        exp_q.delete();
        flush = 1'b0;
        drive(0, 32'h0, 16'h0, 0);
        check("flush_out_valid", 64'(out_valid), 64'h0);
        check("flush_out_ctrl", 64'(out_ctrl), 64'h0);
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_d_holds", 64'(out_data), 64'hC1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            tick();
            check("flush_no_emerge", 64'(out_valid), 64'h0);
        end

        // Flush while the head entry is being taken: only the head transfers.
        out_ready = 1'b0;
        drive(1, 32'hD1, 16'h00D1, 1); tick();
        drive(1, 32'hD2, 16'h00D2, 1); tick();
        drive(1, 32'hD3, 16'h00D3, 1); tick();
        drive(0, 32'h0, 16'h0, 0);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        exp_q.delete();
        flush = 1'b0;
        check("flush_xfer_occ", 64'(occupancy), 64'd0);
        check("flush_xfer_valid", 64'(out_valid), 64'h0);

        // Asynchronous reset mid-stream.
        drive(1, 32'hE1, 16'h00E1, 1); tick();
        drive(1, 32'hE2, 16'h00E2, 1); tick();
        drive(1, 32'hE3, 16'h00E3, 1); tick();
        drive(0, 32'h0, 16'h0, 0);
        #1;
        Reset = 1'b0;
        exp_q.delete();
        #1;
        check("arst_out_valid", 64'(out_valid), 64'h0);
        check("arst_out_data",  64'(out_data),  64'h0);
        check("arst_out_ctrl",  64'(out_ctrl),  64'h0);
        check("arst_occ",       64'(occupancy), 64'd0);
        tick();
        Reset = 1'b1;
        tick();
        check("arst_post_valid", 64'(out_valid), 64'h0);
        drive(1, 32'h55, 16'h0055, 1);
        tick(); drive(0, 32'h0, 16'h0, 0);
        check("arst_lat1", 64'(out_valid), 64'h0);
        tick(); check("arst_lat2", 64'(out_valid), 64'h0);
        tick(); check("arst_lat3_v", 64'(out_valid), 64'h1); check("arst_lat3_d", 64'(out_data), 64'h55);
        tick(); check("arst_drained", 64'(occupancy), 64'd0);

`ifdef PIPE_PARITY_EN
        // Single-bit corruption of the last-stage payload.
        out_ready = 1'b0;
        drive(1, 32'hF1, 16'h00F1, 1); tick();
        drive(0, 32'h0, 16'h0, 0); tick(); tick();
        check("par_clean_head", 64'(par_err), 64'h0);
        corrupting = 1'b1;
        force u_dut.g_stage[DEPTH-1].d_q = 32'h000000F0;
        #1;
        check("par_err_flip", 64'(par_err), 64'h1);
        release u_dut.g_stage[DEPTH-1].d_q;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        check("par_err_after_flush", 64'(par_err), 64'h0);
        corrupting = 1'b0;
`endif

        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised successor to the fixed X-stage pipeline registers: a DEPTH-deep chain of pipeline registers carrying a DATA_W datapath payload and a CTRL_W control bundle.
- Adds per-stage valid bits and a valid/ready handshake with bubble collapsing, so an empty stage fills even while downstream is stalled.
- Adds a synchronous flush that turns every in-flight entry into a bubble, plus an occupancy count.
- Sits between any two pipeline phases, for example X2 to X3 or EX to MEM, replacing hand-written per-stage register modules.

Parameters:
- DATA_W, 32, width of datapath payload: instruction, PC+4, ALU/mem results packed by the instantiator.
- CTRL_W, 16, width of control bundle: RegWrite, MemToReg, etc. Forced to 0 in bubbles.
- DEPTH, 2, number of register stages. Legal range 1..8.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset. 0 resets all state immediately.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  chain accepts an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bundle.
- flush  in  1  synchronous kill of all in-flight entries.
- out_valid  out  1  last stage holds a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  last-stage payload.
- out_ctrl  out  CTRL_W  last-stage control; 0 whenever out_valid=0.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages, combinational from the valid bits.
- par_err  out  1  present only with PIPE_PARITY_EN.

Behaviour:
- Stages are numbered 0 (input side) to DEPTH-1 (output side). Each stage holds v[k], d[k] and c[k].
- Reset low (asynchronous): all v=0, d=0, c=0, so out_valid=0, out_data=0, out_ctrl=0 and occupancy=0. Release is synchronous to Clk. Reset mid-transfer discards all entries without producing any output.
- Ready chain (combinational):
  - r[DEPTH] = out_ready.
  - r[k] = !v[k] | r[k+1].
  - in_ready = r[0] & !flush.
- Stage update on posedge Clk, when flush=0:
  - Stage k loads when r[k]=1. It takes the upstream stage's (v,d,c), with stage 0 taking (in_valid,in_data,in_ctrl).
  - When the loaded valid is 0, c[k] loads 0 and d[k] holds its old value.
  - When r[k]=0, stage k holds v, d and c unchanged.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Latency: with out_ready held 1, an accepted entry appears at the output exactly DEPTH cycles later. Throughput is 1 entry per cycle.
- Backpressure: with out_ready=0 and the chain full, in_ready=0 and all stages hold. When out_ready rises, in_ready rises in the same cycle (combinational path, no bubble).
- Bubble collapsing: a stage with v=0 always loads, even while later stages stall.
- Flush (synchronous, highest priority after reset):
  - All v clear to 0 and all c clear to 0 at the next edge; d holds.
  - in_ready=0 during the flush cycle, so an in_valid entry in that cycle is not accepted.
  - An out_valid entry in the flush cycle is considered transferred only if out_ready=1.
- Invariant: out_ctrl==0 whenever out_valid==0. occupancy never exceeds DEPTH.
- DEPTH=1: a single skid-less register, in_ready = !v[0] | out_ready.

Optional Feature:
- Macro PIPE_PARITY_EN.
- Defined:
  - Each stage stores an even-parity bit p[k] over {in_data,in_ctrl}, computed at stage 0 and carried unchanged down the chain.
  - par_err = out_valid & (^{out_data,out_ctrl,p[DEPTH-1]}), combinational.
  - p resets to 0 and clears on flush.
- Undefined: no parity storage and no par_err port.

Test Plan:
- Streaming: DEPTH=2, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> same values at out_data on cycles 2,3,4, out_valid high 3 cycles, occupancy peaks at 2.
- Backpressure: DEPTH=3, fill with 0xA1..0xA3, out_ready=0 -> in_ready=0, occupancy=3, out_data stays 0xA1 for 5 cycles. Raise out_ready -> in_ready=1 same cycle, drain order A1,A2,A3.
- Bubble collapse: DEPTH=3, push 0xB1, idle a cycle, push 0xB2, out_ready=0 -> B1 and B2 end up in adjacent stages 2 and 1, occupancy=2, in_ready=1.
- Flush: chain full with in_ctrl=0xFFFF entries, flush=1 with in_valid=1 -> in_ready=0 that cycle; next cycle out_valid=0, out_ctrl=0, occupancy=0; the flush-cycle entry never emerges.
- Async reset: assert Reset=0 mid-stream between clock edges -> outputs and occupancy go 0 before the next edge. After release, first push 0x55 emerges DEPTH cycles later.
- PIPE_PARITY_EN: force a single bit flip on d[DEPTH-1] via the bench -> par_err=1 while that entry is valid. Clean traffic -> par_err=0 throughout.
